// File: rtl/mem_port_arbiter.sv
// Arbitrates N_CH load/store clients onto one byte-wide RAM/IO bus, one byte beat per cycle.
// Loads are reassembled from beats and sign/zero-extended; rdy_in low freezes the block.
module mem_port_arbiter #(
    parameter int         N_CH       = 2,
    parameter int         ARB_MODE   = 1,
    parameter logic [7:0] FLUSH_MASK = 8'b01
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 io_buffer_full,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [32*N_CH-1:0]   req_addr,
    input  logic [32*N_CH-1:0]   req_wdata,
    input  logic [N_CH-1:0]      req_r_nw,
    input  logic [3*N_CH-1:0]    req_type,
    output logic [N_CH-1:0]      rsp_done,
    output logic [31:0]          rsp_data,
    output logic                 busy,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_asm;
    logic            r_r_nw;
    logic [2:0]      r_type;
    logic [CW-1:0]   r_chan;
    logic [CW-1:0]   r_rr_ptr;
    logic [1:0]      r_k;
    logic            r_cap_vld;
    logic [1:0]      r_cap_idx;

    logic            w_grant_vld;
    logic [CW-1:0]   w_grant_idx;
    logic [CW-1:0]   w_base;
    logic [N_CH-1:0] w_rot;
    logic [1:0]      w_last_k;
    logic [31:0]     w_beat_addr;
    logic            w_stall;
    logic            w_flush;
    logic            w_go;
    logic [N_CH-1:0] w_chan_oh;
    logic [31:0]     w_ext;

    // Fixed priority is round-robin with the search always starting just after the last channel.
    always_comb begin
        w_base      = (ARB_MODE == 0) ? CW'(N_CH - 1) : r_rr_ptr;
        w_rot       = N_CH'({req_valid, req_valid} >> (int'(w_base) + 1));
        w_grant_vld = |req_valid;
        w_grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_grant_idx = CW'((int'(w_base) + 1 + i) % N_CH);
            end
        end
    end

    always_comb begin
        w_last_k    = (r_type[1:0] == 2'b00) ? 2'd0 : (r_type[1:0] == 2'b01) ? 2'd1 : 2'd3;
        w_beat_addr = r_addr + {30'd0, r_k};
        w_chan_oh   = N_CH'(1) << r_chan;
        w_go        = rdy_in && !rst_in;
        w_stall     = (r_state == S_XFER) && !r_r_nw && (w_beat_addr[17:16] == 2'b11) && io_buffer_full;
        w_flush     = flush_in && r_r_nw && (r_state != S_IDLE) && |(w_chan_oh & FLUSH_MASK[N_CH-1:0]);
        case (r_type)
            3'b000:  w_ext = {{24{r_asm[7]}}, r_asm[7:0]};
            3'b001:  w_ext = {{16{r_asm[15]}}, r_asm[15:0]};
            3'b100:  w_ext = {24'd0, r_asm[7:0]};
            3'b101:  w_ext = {16'd0, r_asm[15:0]};
            default: w_ext = r_asm;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant_vld) w_state_nxt = S_XFER;
            S_XFER: if (!w_stall && (r_k == w_last_k)) w_state_nxt = r_r_nw ? S_WAIT : S_DONE;
            S_WAIT: w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_flush) begin
            w_state_nxt = S_IDLE;
        end
        busy     = (r_state != S_IDLE);
        mem_a    = (r_state == S_XFER) ? w_beat_addr : 32'd0;
        mem_dout = (r_state == S_XFER) ? r_wdata[{r_k, 3'b000} +: 8] : 8'd0;
        mem_wr   = w_go && (r_state == S_XFER) && !r_r_nw && !w_stall;
        rsp_done = (w_go && (r_state == S_DONE) && !w_flush) ? w_chan_oh : '0;
        rsp_data = (r_state == S_DONE) ? w_ext : 32'd0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
        end
    end

    // Read byte returns the cycle after its beat, so capture is not gated by rdy_in.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_asm     <= '0;
            r_r_nw    <= 1'b0;
            r_type    <= '0;
            r_chan    <= '0;
            r_rr_ptr  <= CW'(N_CH - 1);
            r_k       <= '0;
            r_cap_vld <= 1'b0;
            r_cap_idx <= '0;
        end else begin
            if (r_cap_vld) begin
                r_asm[{r_cap_idx, 3'b000} +: 8] <= mem_din;
                r_cap_vld                       <= 1'b0;
            end
            if (rdy_in) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_grant_vld) begin
                            r_addr   <= req_addr[32*int'(w_grant_idx) +: 32];
                            r_wdata  <= req_wdata[32*int'(w_grant_idx) +: 32];
                            r_r_nw   <= req_r_nw[w_grant_idx];
                            r_type   <= req_type[3*int'(w_grant_idx) +: 3];
                            r_chan   <= w_grant_idx;
                            r_rr_ptr <= w_grant_idx;
                            r_k      <= '0;
                        end
                    end
                    S_XFER: begin
                        if (!w_stall && !w_flush) begin
                            if (r_r_nw) begin
                                r_cap_vld <= 1'b1;
                                r_cap_idx <= r_k;
                            end
                            if (r_k != w_last_k) begin
                                r_k <= r_k + 2'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin DUT plus a fixed-priority twin.
module tb_mem_port_arbiter;
    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, io_buffer_full;
    logic [1:0]  req_valid, req_r_nw;
    logic [63:0] req_addr, req_wdata;
    logic [5:0]  req_type;
    logic [1:0]  rsp_done;
    logic [31:0] rsp_data, mem_a;
    logic        busy, mem_wr;
    logic [7:0]  mem_din, mem_dout;
    logic [1:0]  fp_rsp_done;
    logic [31:0] fp_rsp_data, fp_mem_a;
    logic        fp_busy, fp_mem_wr;
    logic [7:0]  fp_mem_dout;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] data;
        logic        chk_data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [39:0] wlog[$];
    logic [7:0]  ram [0:65535];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          t4_win = 1'b0;
    int          fp0_cnt = 0;
    int          fp1_cnt = 0;

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(posedge clk_in) mem_din <= ram[mem_a[15:0]];

    mem_port_arbiter #(.N_CH(2), .ARB_MODE(1), .FLUSH_MASK(8'b01)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_r_nw(req_r_nw), .req_type(req_type),
        .rsp_done(rsp_done), .rsp_data(rsp_data), .busy(busy), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr));

    mem_port_arbiter #(.N_CH(2), .ARB_MODE(0), .FLUSH_MASK(8'b01)) u_fp (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full), .req_valid(req_valid), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_r_nw(req_r_nw), .req_type(req_type),
        .rsp_done(fp_rsp_done), .rsp_data(fp_rsp_data), .busy(fp_busy), .mem_din(mem_din),
        .mem_dout(fp_mem_dout), .mem_a(fp_mem_a), .mem_wr(fp_mem_wr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [2:0] ty, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        logic [31:0] a1, a2, a3;
        a1 = a + 1; a2 = a + 2; a3 = a + 3;
        b0 = ram[a[15:0]]; b1 = ram[a1[15:0]]; b2 = ram[a2[15:0]]; b3 = ram[a3[15:0]];
        case (ty)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'd0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'd0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    always @(negedge clk_in) begin
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
        if (t4_win) begin
            if (fp_rsp_done[0]) fp0_cnt++;
            if (fp_rsp_done[1]) fp1_cnt++;
        end
        if (rsp_done !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("spurious_done", {30'd0, rsp_done}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("done_ch", {30'd0, rsp_done}, {62'd0, mon_e.done});
                if (mon_e.chk_data) chk("rsp_data", {32'd0, rsp_data}, {32'd0, mon_e.data});
                chk("done_cyc", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Presents a request for one cycle starting in the current (idle) cycle.
    task automatic issue(input int ch, input logic [31:0] a, input logic [31:0] wd, input logic rnw,
                         input logic [2:0] ty, input bit exp_done, input int extra);
        exp_t e;
        int   n;
        n = (ty[1:0] == 2'b00) ? 1 : (ty[1:0] == 2'b01) ? 2 : 4;
        req_addr[32*ch +: 32]  = a;
        req_wdata[32*ch +: 32] = wd;
        req_type[3*ch +: 3]    = ty;
        req_r_nw[ch]           = rnw;
        req_valid[ch]          = 1'b1;
        if (exp_done) begin
            e.done     = 2'b01 << ch;
            e.data     = ld_model(ty, a);
            e.chk_data = rnw;
            e.cyc      = cyc + n + (rnw ? 2 : 1) + extra;
            sb.push_back(e);
        end
        @(posedge clk_in); #1;
        req_valid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || fp_busy) && t < 60) begin
            @(posedge clk_in); #1;
            t++;
        end
        chk("idle_timeout", {63'd0, busy | fp_busy}, 64'd0);
        @(posedge clk_in); #1;
    endtask

    task automatic check_wlog(input logic [31:0] base, input logic [31:0] data, input int n);
        logic [31:0] ad;
        chk("wlog_len", 64'(wlog.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            ad = base + i;
            if (i < wlog.size()) chk("wlog_beat", {24'd0, wlog[i]}, {24'd0, ad, data[8*i +: 8]});
        end
        wlog.delete();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_r_nw = '0; req_addr = '0; req_wdata = '0; req_type = '0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'hEF; ram[16'h0101] = 8'hBE; ram[16'h0102] = 8'hAD; ram[16'h0103] = 8'hDE;
        ram[16'h0200] = 8'h80; ram[16'h0300] = 8'h34; ram[16'h0301] = 8'h92;
        ram[16'hFFFF] = 8'h5A; ram[16'h0000] = 8'hC3;
        ram[16'h0010] = 8'hF1; ram[16'h0020] = 8'h72;
        repeat (3) @(posedge clk_in);
        #1 rst_in = 1'b0;
        chk("rst_done", {62'd0, rsp_done}, 64'd0);
        chk("rst_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_mem_a", {32'd0, mem_a}, 64'd0);
        chk("rst_dout", {56'd0, mem_dout}, 64'd0);
        chk("rst_wr", {63'd0, mem_wr}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);

        // T1: word load, beat addresses
        issue(0, 32'h100, 32'h0, 1'b1, 3'b010, 1'b1, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t1_mem_a", {32'd0, mem_a}, 64'h100 + 64'(k));
            @(posedge clk_in); #1;
        end
        wait_idle();

        // T2: byte/half loads, signed and unsigned, plus address wrap
        issue(1, 32'h200, 32'h0, 1'b1, 3'b000, 1'b1, 0); wait_idle();
        issue(1, 32'h200, 32'h0, 1'b1, 3'b100, 1'b1, 0); wait_idle();
        issue(0, 32'h300, 32'h0, 1'b1, 3'b001, 1'b1, 0); wait_idle();
        issue(0, 32'h300, 32'h0, 1'b1, 3'b101, 1'b1, 0); wait_idle();
        issue(0, 32'hFFFF_FFFF, 32'h0, 1'b1, 3'b101, 1'b1, 0); wait_idle();

        // T3: IO store stalls on full buffer; plain store ignores it
        io_buffer_full = 1'b1;
        issue(1, 32'h0003_0000, 32'h0000_4241, 1'b0, 3'b001, 1'b1, 3);
        chk("t3_stall_wr", {63'd0, mem_wr}, 64'd0);
        chk("t3_stall_a", {32'd0, mem_a}, 64'h30000);
        @(posedge clk_in); #1; @(posedge clk_in); #1;
        chk("t3_stall_wr2", {63'd0, mem_wr}, 64'd0);
        @(posedge clk_in); #1 io_buffer_full = 1'b0;
        wait_idle();
        check_wlog(32'h0003_0000, 32'h0000_4241, 2);
        io_buffer_full = 1'b1;
        issue(1, 32'h400, 32'hA1B2_C3D4, 1'b0, 3'b010, 1'b1, 0);
        wait_idle();
        io_buffer_full = 1'b0;
        check_wlog(32'h400, 32'hA1B2_C3D4, 4);

        // T4: both channels held; round-robin alternates, fixed priority keeps ch0
        begin
            exp_t e;
            int   c0;
            c0 = cyc;
            req_addr = {32'h20, 32'h10}; req_type = 6'b000_000; req_r_nw = 2'b11;
            req_valid = 2'b11; t4_win = 1'b1;
            for (int g = 0; g < 4; g++) begin
                e.done = (g % 2 == 0) ? 2'b01 : 2'b10;
                e.data = (g % 2 == 0) ? 32'hFFFF_FFF1 : 32'h0000_0072;
                e.chk_data = 1'b1;
                e.cyc = c0 + 3 + 4 * g;
                sb.push_back(e);
            end
            repeat (13) @(posedge clk_in);
            #1 req_valid = 2'b00;
            wait_idle();
            t4_win = 1'b0;
            chk("t4_fp_ch0", 64'(fp0_cnt), 64'd4);
            chk("t4_fp_ch1", 64'(fp1_cnt), 64'd0);
        end

        // T5: flush aborts masked reads only
        issue(0, 32'h100, 32'h0, 1'b1, 3'b010, 1'b0, 0);
        @(posedge clk_in); #1; @(posedge clk_in); #1 flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        chk("t5_flush_busy", {63'd0, busy}, 64'd0);
        wait_idle();
        issue(1, 32'h500, 32'h1122_3344, 1'b0, 3'b010, 1'b1, 0);
        flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        wait_idle();
        check_wlog(32'h500, 32'h1122_3344, 4);
        issue(0, 32'h200, 32'h0, 1'b1, 3'b000, 1'b0, 0);
        flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        chk("t5_last_beat_flush", {63'd0, busy}, 64'd0);
        wait_idle();
        issue(1, 32'h200, 32'h0, 1'b1, 3'b000, 1'b1, 0);
        @(posedge clk_in); #1 flush_in = 1'b1;
        @(posedge clk_in); #1 flush_in = 1'b0;
        wait_idle();

        // T6: freeze mid-load, then reset mid-load
        issue(0, 32'h100, 32'h0, 1'b1, 3'b010, 1'b1, 5);
        @(posedge clk_in); #1 rdy_in = 1'b0;
        chk("t6_freeze_a0", {32'd0, mem_a}, 64'h101);
        repeat (4) begin @(posedge clk_in); #1; end
        chk("t6_freeze_a1", {32'd0, mem_a}, 64'h101);
        chk("t6_freeze_wr", {63'd0, mem_wr}, 64'd0);
        @(posedge clk_in); #1 rdy_in = 1'b1;
        wait_idle();
        issue(0, 32'h100, 32'h0, 1'b1, 3'b010, 1'b0, 0);
        @(posedge clk_in); #1 rst_in = 1'b1;
        @(posedge clk_in); #1 rst_in = 1'b0;
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_mem_a", {32'd0, mem_a}, 64'd0);
        chk("t6_rst_data", {32'd0, rsp_data}, 64'd0);
        wait_idle();
        repeat (3) @(posedge clk_in);
        #1 chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
